// File: rtl/phase_sched.sv
// Adaptive clock-phase scheduler: windowed error counting with req/ack handover to the clock mux.
// Optional statistics outputs (switch_cnt, dwell_max) are enabled by defining PHASE_SCHED_STATS_EN.
module phase_sched #(
    parameter int unsigned WIN_W    = 8,
    parameter int unsigned ERR_TH   = 4,
    parameter int unsigned HOLD_CYC = 64,
    parameter int unsigned HC_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        error_lagging,
    input  logic        error_origin,
    input  logic        error_leading,
    input  logic        mux_ack,
    output logic [1:0]  clk_sel,
    output logic        mux_req,
    output logic        fault,
    output logic        busy
`ifdef PHASE_SCHED_STATS_EN
    ,
    output logic [15:0] switch_cnt,
    output logic [15:0] dwell_max
`endif
);

    localparam int unsigned EC_W = $clog2(ERR_TH + 1);

    localparam logic [EC_W:0]     ERR_TH_L  = (EC_W + 1)'(ERR_TH);
    localparam logic [EC_W-1:0]   ERR_SAT   = EC_W'(ERR_TH);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYC - 1);
    localparam logic [1:0]        SEL_LEAD  = 2'b00;
    localparam logic [1:0]        SEL_ORIG  = 2'b01;
    localparam logic [1:0]        SEL_LAG   = 2'b10;

    typedef enum logic {RUN, SWITCH} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              req_q, req_d;
    logic              fault_q, fault_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [EC_W-1:0]   err_q, err_d;
    logic [HC_W-1:0]   hold_q, hold_d;

    logic              act_err;
    logic [EC_W:0]     err_base;
    logic [EC_W:0]     err_eff;
    logic              step_up;
    logic              step_dn;
    logic              ack_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            sel_q   <= SEL_ORIG;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            win_q   <= '0;
            err_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            win_q   <= win_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        act_err = 1'b0;
        unique case (sel_q)
            SEL_LEAD: act_err = error_leading;
            SEL_ORIG: act_err = error_origin;
            SEL_LAG:  act_err = error_lagging;
            default:  act_err = 1'b0;
        endcase
    end

    // On the wrap cycle the count restarts from this cycle's error alone.
    assign err_base = (win_q == '1) ? '0 : {1'b0, err_q};
    assign err_eff  = err_base + {{EC_W{1'b0}}, act_err};
    assign step_up  = (err_eff >= ERR_TH_L);
    assign step_dn  = !act_err && (hold_q == HOLD_LAST);
    assign ack_ok   = (state_q == SWITCH) && mux_ack && req_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        fault_d = fault_q;
        win_d   = win_q;
        err_d   = err_q;
        hold_d  = hold_q;
        unique case (state_q)
            RUN: begin
                if (!en) begin
                    win_d  = '0;
                    err_d  = '0;
                    hold_d = '0;
                end else begin
                    win_d  = win_q + WIN_W'(1);
                    err_d  = step_up ? ERR_SAT : err_eff[EC_W-1:0];
                    hold_d = act_err ? '0 :
                             ((hold_q == HOLD_LAST) ? hold_q : hold_q + HC_W'(1));
                    if (step_up) begin
                        if (sel_q == SEL_LEAD) begin
                            fault_d = 1'b1;
                            err_d   = '0;
                        end else begin
                            sel_d   = sel_q - 2'd1;
                            req_d   = 1'b1;
                            state_d = SWITCH;
                        end
                    end else if (step_dn && (sel_q != SEL_LAG)) begin
                        sel_d   = sel_q + 2'd1;
                        req_d   = 1'b1;
                        state_d = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (ack_ok) begin
                    req_d   = 1'b0;
                    state_d = RUN;
                    win_d   = '0;
                    err_d   = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign clk_sel = sel_q;
    assign mux_req = req_q;
    assign fault   = fault_q;
    assign busy    = (state_q == SWITCH);

`ifdef PHASE_SCHED_STATS_EN
    logic [15:0] sw_cnt_q;
    logic [15:0] dwell_q;
    logic [15:0] dwell_max_q;
    logic [15:0] dwell_inc;

    assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_cnt_q    <= '0;
            dwell_q     <= '0;
            dwell_max_q <= '0;
        end else begin
            if (ack_ok) begin
                if (sw_cnt_q != '1) sw_cnt_q <= sw_cnt_q + 16'd1;
                dwell_q <= '0;
            end else if (state_q == RUN) begin
                dwell_q <= dwell_inc;
                if (dwell_inc > dwell_max_q) dwell_max_q <= dwell_inc;
            end
        end
    end

    assign switch_cnt = sw_cnt_q;
    assign dwell_max  = dwell_max_q;
`endif

endmodule

// File: tb/tb_phase_sched.sv
// Self-checking bench for phase_sched: directed scenarios plus randomized traffic against a
// behavioural phase/window model; stats ports are checked when PHASE_SCHED_STATS_EN is defined.
module tb_phase_sched;

    localparam int WIN_W    = 8;
    localparam int ERR_TH   = 4;
    localparam int HOLD_CYC = 64;
    localparam int HC_W     = 8;
    localparam int WIN_LEN  = 1 << WIN_W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       e_lag = 1'b0;
    logic       e_org = 1'b0;
    logic       e_lead = 1'b0;
    logic       ack = 1'b0;
    logic [1:0] clk_sel;
    logic       mux_req;
    logic       fault;
    logic       busy;
`ifdef PHASE_SCHED_STATS_EN
    logic [15:0] switch_cnt;
    logic [15:0] dwell_max;
`endif

    phase_sched #(
        .WIN_W   (WIN_W),
        .ERR_TH  (ERR_TH),
        .HOLD_CYC(HOLD_CYC),
        .HC_W    (HC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .error_lagging(e_lag),
        .error_origin (e_org),
        .error_leading(e_lead),
        .mux_ack      (ack),
        .clk_sel      (clk_sel),
        .mux_req      (mux_req),
        .fault        (fault),
        .busy         (busy)
`ifdef PHASE_SCHED_STATS_EN
        ,
        .switch_cnt   (switch_cnt),
        .dwell_max    (dwell_max)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model: conservatism level 0=lagging, 1=origin, 2=leading.
    int m_level;
    int m_win;
    int m_errs;
    int m_clean;
    bit m_req;
    bit m_fault;
    bit m_sw;

    function automatic logic [1:0] lvl2sel(input int l);
        if (l == 0) return 2'b10;
        if (l == 1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".sel"},   16'(clk_sel), 16'(lvl2sel(m_level)));
        chk({tag, ".req"},   16'(mux_req), 16'(m_req));
        chk({tag, ".fault"}, 16'(fault),   16'(m_fault));
        chk({tag, ".busy"},  16'(busy),    16'(m_sw));
    endtask

    task automatic model_reset();
        m_level = 1; m_win = 0; m_errs = 0; m_clean = 0;
        m_req = 0; m_fault = 0; m_sw = 0;
    endtask

    task automatic tick(input bit i_en, input bit lag, input bit org, input bit lead, input bit a);
        int e;
        int cnt;
        bit up;
        bit dn;
        en = i_en; e_lag = lag; e_org = org; e_lead = lead; ack = a;
        if (!m_sw) begin
            if (!i_en) begin
                m_win = 0; m_errs = 0; m_clean = 0;
            end else begin
                e   = (m_level == 0) ? int'(lag) : (m_level == 1) ? int'(org) : int'(lead);
                cnt = ((m_win == WIN_LEN - 1) ? 0 : m_errs) + e;
                m_win = (m_win + 1) % WIN_LEN;
                up = (cnt >= ERR_TH);
                dn = (e == 0) && (m_clean == HOLD_CYC - 1);
                m_errs  = (cnt > ERR_TH) ? ERR_TH : cnt;
                m_clean = (e != 0) ? 0 : ((m_clean + 1 > HOLD_CYC - 1) ? HOLD_CYC - 1 : m_clean + 1);
                if (up) begin
                    if (m_level == 2) begin
                        m_fault = 1; m_errs = 0;
                    end else begin
                        m_level++; m_req = 1; m_sw = 1;
                    end
                end else if (dn && m_level > 0) begin
                    m_level--; m_req = 1; m_sw = 1;
                end
            end
        end else if (a) begin
            m_req = 0; m_sw = 0; m_win = 0; m_errs = 0; m_clean = 0;
        end
        @(posedge clk);
        #1;
        chk_model("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 0; e_lag = 0; e_org = 0; e_lead = 0; ack = 0;
        model_reset();
        #1;
        chk("rst.sel",   16'(clk_sel), 16'h1);
        chk("rst.req",   16'(mux_req), 16'h0);
        chk("rst.fault", 16'(fault),   16'h0);
        chk("rst.busy",  16'(busy),    16'h0);
`ifdef PHASE_SCHED_STATS_EN
        chk("rst.swcnt", switch_cnt, 16'h0);
        chk("rst.dwell", dwell_max,  16'h0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        bit ok;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Clean run in origin: hold expires on the 64th enabled cycle.
        for (int i = 0; i < HOLD_CYC - 1; i++) tick(1, 0, 0, 0, 0);
        chk("hold.pre_sel", 16'(clk_sel), 16'h1);
        chk("hold.pre_req", 16'(mux_req), 16'h0);
        tick(1, 0, 0, 0, 0);
        chk("hold.sel", 16'(clk_sel), 16'h2);
        chk("hold.req", 16'(mux_req), 16'h1);
        tick(1, 0, 0, 0, 1);
        chk("hold.ack_req", 16'(mux_req), 16'h0);
`ifdef PHASE_SCHED_STATS_EN
        chk("hold.swcnt", switch_cnt, 16'h1);
`endif

        // Lagging: 3 errors, then an error on the wrap cycle starts the new window at 1.
        for (int k = 0; k < 3; k++) begin
            tick(1, 1, 0, 0, 0);
            for (int i = 0; i < 10; i++) tick(1, 0, 1, 1, 0);
        end
        guard = 0;
        while (m_win != WIN_LEN - 1 && guard < 2 * WIN_LEN) begin
            tick(1, 0, 0, 0, 0);
            guard++;
        end
        chk("wrap.reached", 16'(m_win == WIN_LEN - 1), 16'h1);
        tick(1, 1, 0, 0, 0);
        chk("wrap.noswitch", 16'(mux_req), 16'h0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0);
            tick(1, 1, 0, 0, 0);
            chk("wrap.nw_req", 16'(mux_req), 16'h0);
        end
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        chk("wrap.up_sel", 16'(clk_sel), 16'h1);
        chk("wrap.up_req", 16'(mux_req), 16'h1);

        // Delayed ack with error traffic: selection and busy held.
        for (int i = 0; i < 20; i++) begin
            tick($urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom), 1'($urandom), 0);
            chk("sw.busy", 16'(busy), 16'h1);
            chk("sw.sel",  16'(clk_sel), 16'h1);
        end
        tick(1, 0, 0, 0, 1);
        chk("sw.done", 16'(busy), 16'h0);

        // Origin: foreign-phase errors ignored; 4th origin error steps to leading.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) tick(1, (i % 2) == 0, 0, (i % 3) == 0, 0);
            if (k == 3) begin
                tick(1, 0, 1, 0, 0);
                chk("up.sel", 16'(clk_sel), 16'h0);
                chk("up.req", 16'(mux_req), 16'h1);
            end else begin
                tick(1, 0, 1, 0, 0);
                chk("up.pre_req", 16'(mux_req), 16'h0);
            end
        end
        tick(1, 0, 0, 0, 1);

        // Leading: threshold sets sticky fault without any request.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, 0);
            tick(1, 0, 0, 1, 0);
        end
        chk("flt.fault", 16'(fault),   16'h1);
        chk("flt.sel",   16'(clk_sel), 16'h0);
        chk("flt.req",   16'(mux_req), 16'h0);
        for (int i = 0; i < 30; i++) tick(1, 0, 0, 0, 0);
        chk("flt.sticky", 16'(fault), 16'h1);

        // Randomized traffic with en toggling and random ack timing.
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 15) != 0,
                 $urandom_range(0, 23) == 0, $urandom_range(0, 23) == 0,
                 $urandom_range(0, 23) == 0, $urandom_range(0, 3) == 0);

        do_reset();
        chk("rst2.fault", 16'(fault), 16'h0);

        // Reset abandons a pending switch asynchronously.
        guard = 0;
        while (!m_sw && guard < 4 * HOLD_CYC) begin
            tick(1, 0, 0, 0, 0);
            guard++;
        end
        ok = m_sw;
        chk("arst.in_switch", 16'(busy), 16'(ok));
        chk("arst.pre_req",   16'(mux_req), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("arst.req",  16'(mux_req), 16'h0);
        chk("arst.sel",  16'(clk_sel), 16'h1);
        chk("arst.busy", 16'(busy),    16'h0);
`ifdef PHASE_SCHED_STATS_EN
        chk("arst.swcnt", switch_cnt, 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/phase_sched.md
Name: phase_sched

Overview:
- Adaptive clock-phase scheduler for the MEDAC error-detecting datapath.
- Counts timing errors reported for the active clock phase over a sliding window.
- Steps the phase select toward a more conservative phase when errors exceed a threshold, and back toward a faster phase after a clean hold interval.
- Each phase change uses a req/ack handshake with the downstream glitch-free clock mux.

Parameters:
- WIN_W, 8: window counter width; window length = 2^WIN_W cycles.
- ERR_TH, 4: errors per window that trigger a step up; legal range 1..2^WIN_W.
- HOLD_CYC, 64: consecutive error-free cycles before a step down; must be ≥1.
- HC_W, 8: hold counter width; must satisfy HOLD_CYC < 2^HC_W.

Ports:
- clk  in  1  block clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enable adaptation; 0 freezes the phase.
- error_lagging  in  1  error flag while the lagging phase is active.
- error_origin  in  1  error flag while the origin phase is active.
- error_leading  in  1  error flag while the leading phase is active.
- mux_ack  in  1  clock mux has completed the switch to clk_sel.
- clk_sel  out  2  phase select: 00 leading, 01 origin, 10 lagging. Never 11.
- mux_req  out  1  switch request; held high until mux_ack.
- fault  out  1  sticky; error threshold reached while already in leading.
- busy  out  1  high while in the SWITCH state.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=RUN, clk_sel=01, mux_req=0, fault=0, busy=0.
  - Window counter, error counter and hold counter all 0.
- Conservatism order: lagging(10) < origin(01) < leading(00).
  - Step up: move one phase toward leading.
  - Step down: move one phase toward lagging.
- Active error: the error input matching the current clk_sel; the other two inputs are ignored.
- State machine:
  - RUN: adaptation active.
  - SWITCH: waiting on the mux handshake.
- Window counter:
  - Free-runs in RUN while en=1 and wraps at 2^WIN_W-1.
  - On the wrap cycle the error counter loads the active error (0 or 1) instead of accumulating. An error on the wrap cycle counts into the new window.
- Error counter:
  - Increments on the active error; saturates at ERR_TH.
  - Step-up condition: err_cnt + active error ≥ ERR_TH in the same cycle.
- Hold counter:
  - Clears on any active error; otherwise increments, saturating.
  - Step-down condition: hold_cnt == HOLD_CYC-1 with no error this cycle.
- RUN, step-up condition true:
  - If clk_sel=00: set fault=1, stay in leading, clear err_cnt, no request.
  - Otherwise: clk_sel steps up next cycle, mux_req=1, go to SWITCH.
- RUN, step-down condition true:
  - If clk_sel=10: no action, hold counter stays saturated.
  - Otherwise: clk_sel steps down, mux_req=1, go to SWITCH.
- Simultaneous step-up and step-down in the same cycle is impossible, because step-down requires no error. If it arises anyway, step-up wins.
- SWITCH:
  - clk_sel is stable; error inputs are ignored; all counters are held.
  - On mux_ack=1: mux_req=0 next cycle, clear all counters, return to RUN.
  - mux_ack sampled while mux_req=0 is ignored.
  - There is no timeout; the block waits indefinitely.
- Latency: the decision cycle's clock edge updates clk_sel and mux_req together, which is one cycle after the error is sampled.
- en=0 in RUN: counters clear, no new requests, clk_sel holds.
- en=0 in SWITCH: the handshake completes normally, then the block idles in RUN.
- fault clears only on reset.
- Reset mid-SWITCH: mux_req drops immediately (async) and clk_sel=01. The mux must tolerate an abandoned request.

Optional Feature:
- Macro: PHASE_SCHED_STATS_EN.
- When defined:
  - Adds output switch_cnt (16 bits), incremented on each accepted mux_ack; saturates at 0xFFFF.
  - Adds output dwell_max (16 bits): longest number of RUN cycles spent in any single phase, saturating.
  - Both reset to 0.
- When undefined: neither port exists and no related logic is synthesised.

Test Plan:
- Reset, then en=1 with no errors, ERR_TH=4, HOLD_CYC=64 -> clk_sel=01 until hold expires at cycle 64. Then clk_sel=10 and mux_req=1; ack -> mux_req=0 next cycle.
- In origin, 4 error_origin pulses within 256 cycles -> clk_sel=00 and mux_req=1 one cycle after the 4th error. error_leading/error_lagging pulses in origin have no effect.
- 3 errors, window wrap, then 1 error on the wrap cycle -> no switch; err_cnt=1 in the new window.
- In leading, 4 error_leading pulses -> fault=1, clk_sel stays 00, mux_req stays 0. fault persists until rst_n=0.
- Step request with mux_ack delayed 20 cycles, errors injected meanwhile -> busy=1 for 20 cycles, clk_sel stable, counters unchanged; after ack, counters are 0.
- rst_n asserted during SWITCH -> mux_req=0 and clk_sel=01 immediately. With stats enabled, switch_cnt=0.
